// File: rtl/rx_packet_buffer_pkg.sv
// rx_packet_buffer_pkg: shared link constants and packet type for the receive buffer
// Provides PKT_WIDTH/pkt_t (shared with transmitter and receiver) and FIFO sizing.
package rx_packet_buffer_pkg;
    localparam int PKT_WIDTH  = 55;
    localparam int PKT_DEPTH  = 4;
    localparam int PKT_ADDR_W = $clog2(PKT_DEPTH);
    typedef logic [PKT_WIDTH-1:0] pkt_t;
    typedef logic [PKT_ADDR_W:0]  cnt_t;
endpackage

// File: rtl/rx_packet_buffer_if.sv
// rx_packet_buffer_if: receiver-side and router-side handshake bundle for rx_packet_buffer
// Receiver side: RX_Data, RX_Data_Valid, RX_Ready.
// Router side:   Pkt_Data, Pkt_Valid, Pkt_Ready.
// Status:        Count, Full, Empty.
// slave = buffer view, master = environment view.
interface rx_packet_buffer_if;
    import rx_packet_buffer_pkg::*;
    pkt_t RX_Data;
    logic RX_Data_Valid;
    logic RX_Ready;
    pkt_t Pkt_Data;
    logic Pkt_Valid;
    logic Pkt_Ready;
    cnt_t Count;
    logic Full;
    logic Empty;
    modport slave (
        input  RX_Data, RX_Data_Valid, Pkt_Ready,
        output RX_Ready, Pkt_Data, Pkt_Valid, Count, Full, Empty
    );
    modport master (
        output RX_Data, RX_Data_Valid, Pkt_Ready,
        input  RX_Ready, Pkt_Data, Pkt_Valid, Count, Full, Empty
    );
endinterface

// File: rtl/rx_pkt_fifo_mem.sv
// rx_pkt_fifo_mem: DEPTH x WIDTH register array, one write port, one asynchronous read port
// Clk_S/Rst_n: clock and asynchronous active-low clear of every entry.
// we_i/waddr_i/wdata_i: write port. raddr_i/rdata_o: combinational read port.
module rx_pkt_fifo_mem #(
    parameter int WIDTH  = 55,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              Clk_S,
    input  logic              Rst_n,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: show-ahead packet FIFO between the serial receiver and the router core
// Clk_S: link clock. Rst_n: asynchronous active-low reset, discards all buffered packets.
// bus (slave): RX_Data/RX_Data_Valid/RX_Ready from the receiver,
//              Pkt_Data/Pkt_Valid/Pkt_Ready to the router core, Count/Full/Empty status.
module rx_packet_buffer
    import rx_packet_buffer_pkg::*;
#(
    parameter int WIDTH  = PKT_WIDTH,
    parameter int DEPTH  = PKT_DEPTH,
    parameter int ADDR_W = PKT_ADDR_W
) (
    input  logic               Clk_S,
    input  logic               Rst_n,
    rx_packet_buffer_if.slave  bus
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              rx_ready_q, rx_ready_d;
    logic              push, pop;
    logic [WIDTH-1:0]  head;

    // RX_Ready is dropped for one cycle after every accepted packet so a
    // receiver that holds RX_Data_Valid one cycle too long is not captured twice.
    always_comb begin
        push       = bus.RX_Data_Valid & rx_ready_q;
        pop        = (count_q != '0) & bus.Pkt_Ready;
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = (push && !pop) ? count_q + 1'b1 :
                     (!push && pop) ? count_q - 1'b1 : count_q;
        rx_ready_d = (count_d < FULL_CNT) & ~push;
    end

    always_ff @(posedge Clk_S or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_ready_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_ready_q <= rx_ready_d;
        end
    end

    rx_pkt_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
        .Clk_S   (Clk_S),
        .Rst_n   (Rst_n),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.RX_Data),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    assign bus.RX_Ready  = rx_ready_q;
    assign bus.Pkt_Data  = head;
    assign bus.Count     = count_q;
    assign bus.Empty     = (count_q == '0);
    assign bus.Full      = (count_q == FULL_CNT);
    assign bus.Pkt_Valid = (count_q != '0);
endmodule

// File: tb/tb_rx_packet_buffer.sv
// tb_rx_packet_buffer: directed stimulus with a scoreboard queue checked by a pop monitor
module tb_rx_packet_buffer;
    import rx_packet_buffer_pkg::*;

    logic Clk_S = 1'b0;
    logic Rst_n;
    int   errors = 0;
    int   checks = 0;
    pkt_t exp_q[$];

    rx_packet_buffer_if bus();

    rx_packet_buffer dut (
        .Clk_S (Clk_S),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk_S = ~Clk_S;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge Clk_S);
        #1;
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", n, act, req);
        end
    endtask

    task automatic send(input pkt_t d);
        bus.RX_Data       = d;
        bus.RX_Data_Valid = 1'b1;
        exp_q.push_back(d);
    endtask

    always @(negedge Clk_S) begin : monitor
        pkt_t e;
        if (Rst_n && bus.Pkt_Valid && bus.Pkt_Ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h, required no packet", bus.Pkt_Data);
            end else begin
                e = exp_q.pop_front();
                if (bus.Pkt_Data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h, required %0h", bus.Pkt_Data, e);
                end
            end
        end
    end

    initial begin
        Rst_n             = 1'b1;
        bus.RX_Data       = 55'h7F;
        bus.RX_Data_Valid = 1'b1;
        bus.Pkt_Ready     = 1'b0;
        #1 Rst_n = 1'b0;
        repeat (10) begin
            cyc();
            chk("rst_rx_ready", 64'(bus.RX_Ready), 64'd0);
            chk("rst_pkt_valid", 64'(bus.Pkt_Valid), 64'd0);
            chk("rst_count", 64'(bus.Count), 64'd0);
            chk("rst_empty", 64'(bus.Empty), 64'd1);
        end
        bus.RX_Data_Valid = 1'b0;
        Rst_n             = 1'b1;
        cyc();
        chk("rel_rx_ready", 64'(bus.RX_Ready), 64'd1);
        chk("rel_full", 64'(bus.Full), 64'd0);

        send(55'd3);
        cyc();
        chk("one_count", 64'(bus.Count), 64'd1);
        chk("one_valid", 64'(bus.Pkt_Valid), 64'd1);
        chk("one_data", 64'(bus.Pkt_Data), 64'd3);
        chk("one_holdoff", 64'(bus.RX_Ready), 64'd0);
        cyc();
        chk("one_no_dup", 64'(bus.Count), 64'd1);
        chk("one_ready_back", 64'(bus.RX_Ready), 64'd1);
        bus.RX_Data_Valid = 1'b0;
        cyc();
        chk("one_stable", 64'(bus.Pkt_Data), 64'd3);
        bus.Pkt_Ready = 1'b1;
        cyc();
        chk("one_drained", 64'(bus.Empty), 64'd1);
        bus.Pkt_Ready = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            send(55'(k));
            cyc();
            chk("fill_count", 64'(bus.Count), 64'(k));
            chk("fill_holdoff", 64'(bus.RX_Ready), 64'd0);
            bus.RX_Data_Valid = 1'b0;
            cyc();
        end
        chk("full_flag", 64'(bus.Full), 64'd1);
        chk("full_rx_ready", 64'(bus.RX_Ready), 64'd0);
        send(55'd5);
        cyc();
        cyc();
        chk("full_no_push", 64'(bus.Count), 64'd4);
        chk("full_rx_ready2", 64'(bus.RX_Ready), 64'd0);
        chk("full_head", 64'(bus.Pkt_Data), 64'd1);
        bus.Pkt_Ready = 1'b1;
        cyc();
        chk("free_count", 64'(bus.Count), 64'd3);
        chk("free_rx_ready", 64'(bus.RX_Ready), 64'd1);
        cyc();
        chk("wrap_pushpop_count", 64'(bus.Count), 64'd3);
        chk("wrap_holdoff", 64'(bus.RX_Ready), 64'd0);
        bus.RX_Data_Valid = 1'b0;
        repeat (3) cyc();
        chk("wrap_empty", 64'(bus.Empty), 64'd1);
        bus.Pkt_Ready = 1'b0;

        send(55'h11);
        cyc();
        bus.RX_Data_Valid = 1'b0;
        cyc();
        send(55'h22);
        cyc();
        bus.RX_Data_Valid = 1'b0;
        cyc();
        chk("sim_pre_count", 64'(bus.Count), 64'd2);
        send(55'h2AAAAAAAAAAAAA);
        bus.Pkt_Ready = 1'b1;
        cyc();
        chk("sim_count", 64'(bus.Count), 64'd2);
        chk("sim_head", 64'(bus.Pkt_Data), 64'h22);
        bus.RX_Data_Valid = 1'b0;
        cyc();
        chk("sim_last", 64'(bus.Pkt_Data), 64'h2AAAAAAAAAAAAA);
        cyc();
        chk("sim_empty", 64'(bus.Count), 64'd0);

        repeat (5) begin
            cyc();
            chk("epop_count", 64'(bus.Count), 64'd0);
            chk("epop_valid", 64'(bus.Pkt_Valid), 64'd0);
        end
        bus.Pkt_Ready = 1'b0;
        send(55'h5A5);
        cyc();
        chk("epop_next_data", 64'(bus.Pkt_Data), 64'h5A5);
        chk("epop_next_count", 64'(bus.Count), 64'd1);
        bus.RX_Data_Valid = 1'b0;
        cyc();
        send(55'hE);
        cyc();
        bus.RX_Data_Valid = 1'b0;
        cyc();
        send(55'hF);
        cyc();
        bus.RX_Data_Valid = 1'b0;
        chk("mid_count", 64'(bus.Count), 64'd3);
        #2 Rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 64'(bus.Count), 64'd0);
        chk("mid_rst_valid", 64'(bus.Pkt_Valid), 64'd0);
        chk("mid_rst_rx_ready", 64'(bus.RX_Ready), 64'd0);
        chk("mid_rst_data", 64'(bus.Pkt_Data), 64'd0);
        exp_q.delete();
        cyc();
        Rst_n = 1'b1;
        cyc();
        chk("mid_rel_rx_ready", 64'(bus.RX_Ready), 64'd1);
        send(55'h77);
        cyc();
        chk("mid_new_count", 64'(bus.Count), 64'd1);
        chk("mid_new_data", 64'(bus.Pkt_Data), 64'h77);
        bus.RX_Data_Valid = 1'b0;
        bus.Pkt_Ready     = 1'b1;
        cyc();
        chk("mid_new_drained", 64'(bus.Empty), 64'd1);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
